// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM encodings, default widths, reset values.
// Latency: n/a; backpressure: n/a.
package if_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_STALL = 2'd2;

    localparam logic [1:0] RST_STATE = S_IDLE;
    localparam logic       RST_PEND  = 1'b0;

endpackage

// File: rtl/instr_queue.sv
// Generic synchronous FIFO holding fetched {addr, instr} entries; head is read straight from the entry registers.
// Latency: push visible at head next cycle; backpressure: push dropped only when full without a pop, pop ignored when empty.
module instr_queue #(
    parameter int DEPTH = 2,
    parameter int W     = 16,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_dat = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction prefetcher: issues program-memory reads at pc_addr and queues {addr, data}; optional flush via INSTR_FETCH_FLUSH_EN.
// Latency: instr_valid two cycles after mem_rd; backpressure: pc_hold/S_STALL once queue + in-flight read would fill the queue.
module instr_fetch
    import if_pkg::*;
#(
    parameter int QUEUE_DEPTH = 2,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_hold,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_valid,
    input  logic              instr_ready
`ifdef INSTR_FETCH_FLUSH_EN
    ,
    input  logic              flush
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              pend;
    logic [ADDR_W-1:0] pend_tag;
    logic [CW-1:0]     count;
    logic              empty;
    logic              pop;
    logic              flush_i;
    logic [CW:0]       occ_nxt;

`ifdef INSTR_FETCH_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign mem_rd      = (state == S_FETCH);
    assign mem_addr    = pc_addr;
    assign pc_hold     = (state == S_STALL);
    assign instr_valid = !empty;
    assign pop         = instr_valid && instr_ready;

    // Occupancy next cycle: queued + in-flight, including this cycle's issue and pop.
    assign occ_nxt = {1'b0, count} + (CW+1)'(pend) + (CW+1)'(mem_rd) - (CW+1)'(pop);

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = S_FETCH;
        end else begin
            case (state)
                S_IDLE:           state_nxt = S_FETCH;
                S_FETCH, S_STALL: state_nxt = (occ_nxt >= (CW+1)'(QUEUE_DEPTH)) ? S_STALL : S_FETCH;
                default:          state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RST_STATE;
            pend     <= RST_PEND;
            pend_tag <= '0;
        end else begin
            state    <= state_nxt;
            pend     <= mem_rd && !flush_i;
            pend_tag <= pc_addr;
        end
    end

    instr_queue #(
        .DEPTH (QUEUE_DEPTH),
        .W     (ADDR_W + DATA_W)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .clr      (flush_i),
        .push     (pend),
        .push_dat ({pend_tag, mem_data}),
        .pop      (pop),
        .head_dat ({instr_addr, instr}),
        .count    (count),
        .empty    (empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: depth-2 instance driven from a vector table, depth-4 instance for streaming and flush.
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] pc2, ma2, md2, ins2, ia2;
    logic       hold2, rd2, vld2, rdy2;
    logic [7:0] pc4, ma4, md4, ins4, ia4;
    logic       hold4, rd4, vld4, rdy4;
`ifdef INSTR_FETCH_FLUSH_EN
    logic       flush = 1'b0;
`endif

    instr_fetch #(.QUEUE_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .pc_addr(pc2), .pc_hold(hold2), .mem_addr(ma2),
        .mem_rd(rd2), .mem_data(md2), .instr(ins2), .instr_addr(ia2),
        .instr_valid(vld2), .instr_ready(rdy2)
`ifdef INSTR_FETCH_FLUSH_EN
        , .flush(1'b0)
`endif
    );

    instr_fetch #(.QUEUE_DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .pc_addr(pc4), .pc_hold(hold4), .mem_addr(ma4),
        .mem_rd(rd4), .mem_data(md4), .instr(ins4), .instr_addr(ia4),
        .instr_valid(vld4), .instr_ready(rdy4)
`ifdef INSTR_FETCH_FLUSH_EN
        , .flush(flush)
`endif
    );

    // Program counter advances only when a read is issued; memory returns addr ^ A5 one cycle later.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc2 <= 8'h00;
        else if (rd2) pc2 <= pc2 + 8'd1;
    end
    always @(posedge clk or negedge rst) begin
        if (!rst) pc4 <= 8'h00;
        else if (rd4) pc4 <= pc4 + 8'd1;
    end
    always @(posedge clk) md2 <= ma2 ^ 8'hA5;
    always @(posedge clk) md4 <= ma4 ^ 8'hA5;

    typedef struct {
        logic       rdy;
        logic       rd;
        logic       hold;
        logic       vld;
        logic [7:0] mad;
        logic [7:0] ia;
        logic [7:0] ins;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input int stp, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, stp, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rd2",   0, {7'd0, rd2},   8'h00);
        chk("rst_hold2", 0, {7'd0, hold2}, 8'h00);
        chk("rst_vld2",  0, {7'd0, vld2},  8'h00);
        chk("rst_ins2",  0, ins2,          8'h00);
        chk("rst_ia2",   0, ia2,           8'h00);
        chk("rst_ma2",   0, ma2,           8'h00);
        chk("rst_vld4",  0, {7'd0, vld4},  8'h00);
        chk("rst_rd4",   0, {7'd0, rd4},   8'h00);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rdy2 = 1'b0;
        rdy4 = 1'b1;

        //            rdy   rd    hold  vld   mem_addr ia     ins
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'hA5};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'hA5};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'hA5};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 8'h00, 8'hA5};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h01, 8'hA4};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 8'h01, 8'hA4};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h03, 8'h01, 8'hA4};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h02, 8'hA7};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 8'h03, 8'hA6};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h05, 8'h04, 8'hA1};

        // Depth-2 fill, stall, single-pop refill, pop-while-empty.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            rdy2 = tbl[i].rdy;
            #1;
            chk("tbl_rd",   i, {7'd0, rd2},   {7'd0, tbl[i].rd});
            chk("tbl_hold", i, {7'd0, hold2}, {7'd0, tbl[i].hold});
            chk("tbl_vld",  i, {7'd0, vld2},  {7'd0, tbl[i].vld});
            chk("tbl_madr", i, ma2,           tbl[i].mad);
            if (tbl[i].vld) begin
                chk("tbl_iadr",  i, ia2,  tbl[i].ia);
                chk("tbl_instr", i, ins2, tbl[i].ins);
            end
            @(negedge clk);
        end

        // Reset while a read is in flight: the returning data must not be queued.
        rdy2 = 1'b0;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_pre_rd", 2, {7'd0, rd2}, 8'h01);
        rst = 1'b0;
        #1;
        chk("mid_rd",   0, {7'd0, rd2},   8'h00);
        chk("mid_hold", 0, {7'd0, hold2}, 8'h00);
        chk("mid_vld",  0, {7'd0, vld2},  8'h00);
        chk("mid_ins",  0, ins2,          8'h00);
        chk("mid_ia",   0, ia2,           8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post_vld", k, {7'd0, vld2}, (k == 3) ? 8'h01 : 8'h00);
            if (k == 3) begin
                chk("post_ia",  k, ia2,  8'h00);
                chk("post_ins", k, ins2, 8'hA5);
            end
            @(negedge clk);
        end

        // Depth-4 streaming with instr_ready held high: one instruction per cycle from step 3.
        rdy4 = 1'b1;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            #1;
            chk("str_vld",  k, {7'd0, vld4},  (k >= 3) ? 8'h01 : 8'h00);
            chk("str_hold", k, {7'd0, hold4}, 8'h00);
            if (k >= 3) begin
                chk("str_ia",  k, ia4,  8'(k - 3));
                chk("str_ins", k, ins4, 8'(k - 3) ^ 8'hA5);
            end
            @(negedge clk);
        end

`ifdef INSTR_FETCH_FLUSH_EN
        // Flush with two entries queued and one read pending.
        rdy4 = 1'b0;
        do_reset();
        repeat (4) @(negedge clk);
        #1;
        chk("fl_pre_vld", 4, {7'd0, vld4}, 8'h01);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_vld",  5, {7'd0, vld4},  8'h00);
        chk("fl_hold", 5, {7'd0, hold4}, 8'h00);
        chk("fl_rd",   5, {7'd0, rd4},   8'h01);
        chk("fl_madr", 5, ma4,           8'h04);
        @(negedge clk);
        #1;
        chk("fl_vld6", 6, {7'd0, vld4}, 8'h00);
        @(negedge clk);
        #1;
        chk("fl_vld7", 7, {7'd0, vld4}, 8'h01);
        chk("fl_ia7",  7, ia4,          8'h04);
        chk("fl_ins7", 7, ins4,         8'hA1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter: QUEUE_DEPTH, 2, instruction queue entries; power of two, 2..8.
REQ-002 Parameter: ADDR_W, 8, program address width.
REQ-003 Parameter: DATA_W, 8, instruction word width.
REQ-004 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-low reset.
REQ-006 Port: pc_addr  input  ADDR_W  current program-counter address.
REQ-007 Port: pc_hold  output  1  high requests that the program counter not advance.
REQ-008 Port: mem_addr  output  ADDR_W  program-memory read address.
REQ-009 Port: mem_rd  output  1  program-memory read strobe.
REQ-010 Port: mem_data  input  DATA_W  read data, valid exactly one cycle after mem_rd.
REQ-011 Port: instr  output  DATA_W  head-of-queue instruction.
REQ-012 Port: instr_addr  output  ADDR_W  address of the head-of-queue instruction.
REQ-013 Port: instr_valid  output  1  queue non-empty.
REQ-014 Port: instr_ready  input  1  decoder accepts the head entry when high with instr_valid.
REQ-015 Port: flush  input  1  discard queued and in-flight fetches (present only with INSTR_FETCH_FLUSH_EN).

Function
REQ-016 The FSM SHALL have three states: S_IDLE, S_FETCH and S_STALL.
REQ-017 S_IDLE SHALL be entered on reset, SHALL hold mem_rd low, and SHALL go to S_FETCH on the first clock edge after rst deasserts.
REQ-018 In S_FETCH, mem_rd SHALL be 1 and mem_addr SHALL equal pc_addr combinationally; each such cycle records a pending read tagged with pc_addr.
REQ-019 A pending read SHALL capture mem_data and its tag into the queue tail on the next rising edge, so instr_valid rises two cycles after the issuing mem_rd.
REQ-020 Occupancy SHALL be defined as queue count plus pending reads (0 or 1).
REQ-021 pc_hold SHALL be 1 whenever next-cycle occupancy, after this cycle's pops, would reach QUEUE_DEPTH; the FSM SHALL be in S_STALL, with mem_rd 0, exactly while pc_hold is 1.
REQ-022 S_STALL SHALL return to S_FETCH in the cycle after a pop frees an entry; no read SHALL be issued that could overflow the queue.
REQ-023 A pop SHALL occur when instr_valid and instr_ready are both 1; when a push and a pop occur in the same cycle, count SHALL be unchanged and order SHALL be preserved.
REQ-024 instr_ready while the queue is empty SHALL have no effect; the queue SHALL never underflow or overflow.
REQ-025 Queue pointers SHALL wrap modulo QUEUE_DEPTH, and the count SHALL be clog2(QUEUE_DEPTH)+1 bits wide.
REQ-026 instr and instr_addr SHALL be registered queue outputs and SHALL hold stable while instr_valid is 1 and instr_ready is 0.

Reset
REQ-027 rst low SHALL asynchronously force: S_IDLE; empty queue; pending cleared; pc_hold 0; mem_rd 0; mem_addr driven by pc_addr; instr_valid 0; instr 0; instr_addr 0.
REQ-028 Reset asserted mid-fetch SHALL discard the in-flight read; mem_data arriving after reset SHALL be ignored.

Configuration
REQ-029 Macro INSTR_FETCH_FLUSH_EN: when defined, the flush port SHALL exist, and flush=1 SHALL empty the queue, void any pending read (its mem_data is not captured), and force S_FETCH on the next edge.
REQ-030 With flush=1, instr_valid and pc_hold SHALL be 0 in the following cycle, and flush SHALL take priority over a simultaneous push or pop.
REQ-031 When INSTR_FETCH_FLUSH_EN is undefined, the flush port and its logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-032 A shared package if_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults and the reset-value constants.
REQ-033 The queue SHALL be one sub-module, instr_queue: a synchronous FIFO with push/pop/count and an asynchronous active-low reset.

Verification
REQ-034 Reset then continuous instr_ready=1, with memory returning data = addr XOR 8'hA5 and the program counter incrementing from 8'h00 -> instr_valid first at cycle 3, instr=8'hA5, instr_addr=8'h00, then one instruction per cycle in order.
REQ-035 instr_ready=0 with QUEUE_DEPTH=2 -> exactly 2 mem_rd pulses, pc_hold=1 thereafter, queue holds addresses 00 and 01 stable.
REQ-036 From the full state, a one-cycle instr_ready pulse -> one pop, and exactly one new mem_rd in the following cycle at the held pc_addr.
REQ-037 rst driven low between mem_rd and its data -> all outputs at reset values immediately; no entry captured after release.
REQ-038 (INSTR_FETCH_FLUSH_EN) flush with 2 queued entries and 1 pending -> next cycle instr_valid=0 and pc_hold=0; the pending data is never delivered.
REQ-039 Push and pop in the same cycle with count=1 -> count stays 1 and instr_addr advances by 1.
